bsg_cache_dma_mem_responder: RTL and testbench
==============================================

# bsg_cache_dma_mem_responder

Synthesizable memory-side responder for the bsg_cache DMA interface. It accepts fill (read) and evict (write) DMA packets from a cache, streams block data back to the cache, and absorbs evicted block data. A flop-array backing store holds the data. It sits at the far end of the cache's dma_pkt/dma_data channels, so a cache can run in FPGA or emulation builds without a nonsynthesizable model.

## Interface
Parameters:
- addr_width_p, 30, byte-address width of the DMA packet
- data_width_p, 32, word width of the data channels; a power of 2, at least 8
- block_size_in_words_p, 8, words per cache block; a power of 2
- els_p, 1024, backing-store depth in words; a power of 2 and a multiple of block_size_in_words_p

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- dma_pkt_i  in  1+block_size_in_words_p+addr_width_p  {write_not_read (MSB), mask, addr (LSBs)}
- dma_pkt_v_i  in  1  packet valid
- dma_pkt_yumi_o  out  1  packet consumed this cycle
- dma_data_o  out  data_width_p  fill data to the cache
- dma_data_v_o  out  1  fill data valid
- dma_data_ready_i  in  1  cache can accept fill data
- dma_data_i  in  data_width_p  evict data from the cache
- dma_data_v_i  in  1  evict data valid
- dma_data_yumi_o  out  1  evict word consumed this cycle
- busy_o  out  1  a transaction is in progress (state != IDLE)

## Operation
- FSM states: IDLE, READ, WRITE. There is a beat counter cnt_r of width lg(block_size_in_words_p) and a base register base_r of width lg(els_p).
- IDLE:
  - dma_pkt_yumi_o = dma_pkt_v_i.
  - On yumi, latch mask, then compute base_r = (addr >> lg(data_width_p/8)) with the low lg(block_size_in_words_p) bits cleared, truncated mod els_p. Out-of-range addresses alias; there is no error signal.
  - Go to WRITE if write_not_read, else READ. Clear cnt_r to 0.
- READ:
  - dma_data_v_o = 1 and dma_data_o = mem[base_r + cnt_r]. This is a combinational read of the flop array.
  - On dma_data_v_o & dma_data_ready_i, increment cnt_r.
  - On the beat with cnt_r == block_size_in_words_p-1, go to IDLE and wrap cnt_r to 0.
- WRITE:
  - dma_data_yumi_o = dma_data_v_i.
  - On yumi, if mask[cnt_r] then mem[base_r + cnt_r] <= dma_data_i. Otherwise the word is consumed and discarded.
  - Increment cnt_r. The last beat (cnt_r == max) returns to IDLE.
- Words are transferred in order, word 0 first. There is no reordering and no critical-word-first ordering.
- Only one transaction is in flight. dma_pkt_yumi_o is 0 outside IDLE.
- dma_data_yumi_o is 0 outside WRITE, and dma_data_v_o is 0 outside READ. Data presented on the unused channel is ignored.
- Memory contents are not reset and are X until written.

## Timing
- Reset values: state IDLE, cnt_r 0, dma_pkt_yumi_o 0 (while dma_pkt_v_i is 0), dma_data_v_o 0, dma_data_yumi_o 0, busy_o 0. base_r and mask are don't-care.
- dma_pkt_yumi_o and dma_data_yumi_o depend combinationally on their v inputs. dma_data_v_o depends only on state.
- A packet is consumed in cycle N. In cycle N+1 the FSM is in READ or WRITE, with word 0 on the channel or accepted that cycle.
- Read with ready held high: beats occur in N+1 .. N+B, where B = block_size_in_words_p. IDLE is reached in N+B+1, and the earliest next yumi is N+B+1.
- Write with v held high: the same beat and IDLE cycles apply. A write to mem in beat k is visible to a READ combinationally from the cycle after it.
- Backpressure: dropping ready_i or v_i stalls cnt_r. dma_data_o stays stable while v_o=1 and ready_i=0.
- Back-to-back packets are never overlapped. A pkt_v asserted during a transaction waits until IDLE.
- Reset mid-transaction forces IDLE and cnt_r = 0 on the next edge. Words already written remain in memory. Remaining beats are abandoned, and the cache must also be reset.
- The reset input is sampled on the clock edge only.

## Test plan
(B=8, data_width_p=32, els_p=1024.)
- Full write then read: write pkt at addr 0x100 with mask 0xFF, data 0xA0..0xA7 at v=1 continuously. Then a read pkt at 0x100 returns 0xA0..0xA7 on 8 consecutive cycles starting the cycle after the yumi. busy_o is high for exactly 8 cycles.
- Masked write: prefill addr 0x200 with 0x11 in every word. Write mask 0x0F with 0xB0..0xB7. The read must return B0,B1,B2,B3,11,11,11,11. All 8 write beats are still yumi'd.
- Address alignment and alias: a write at 0x11C (mid-block) must land at block base 0x100. A read at 0x100+4096 (els_p*4) returns the same block.
- Backpressure: during a read, toggle ready_i with a random pattern. The bench must see exactly 8 accepted beats, in order, with dma_data_o held while stalled. Likewise, random dma_data_v_i during a write must yield the correct memory image.
- Pkt while busy: hold dma_pkt_v_i high throughout a read. The second yumi must occur exactly 1 cycle after the final data beat, and never earlier.
- Reset mid-read after beat 3: the next cycle shows IDLE, busy_o=0 and dma_data_v_o=0. A fresh read from word 0 returns correct data.

Source files
------------

// File: rtl/bsg_cache_dma_mem_responder.sv
//------------------------------------------------------------------------------
// Module  : bsg_cache_dma_mem_responder
// Brief   : Synthesizable memory-side responder for bsg_cache DMA fill/evict.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module bsg_cache_dma_mem_responder #(
    parameter int addr_width_p          = 30,
    parameter int data_width_p          = 32,
    parameter int block_size_in_words_p = 8,
    parameter int els_p                 = 1024
) (
    input  logic                                          clk,
    input  logic                                          reset,

    input  logic [1+block_size_in_words_p+addr_width_p-1:0] dma_pkt_i,
    input  logic                                          dma_pkt_v_i,
    output logic                                          dma_pkt_yumi_o,

    output logic [data_width_p-1:0]                       dma_data_o,
    output logic                                          dma_data_v_o,
    input  logic                                          dma_data_ready_i,

    input  logic [data_width_p-1:0]                       dma_data_i,
    input  logic                                          dma_data_v_i,
    output logic                                          dma_data_yumi_o,

    output logic                                          busy_o
);

    localparam int lg_block_lp    = (block_size_in_words_p > 1) ? $clog2(block_size_in_words_p) : 1;
    localparam int lg_els_lp      = $clog2(els_p);
    localparam int byte_offset_lp = $clog2(data_width_p / 8);

    localparam logic [lg_els_lp-1:0]   block_mask_lp = lg_els_lp'(block_size_in_words_p - 1);
    localparam logic [lg_block_lp-1:0] last_cnt_lp   = lg_block_lp'(block_size_in_words_p - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } state_e;

    state_e                             state_r, state_n;
    logic [lg_block_lp-1:0]             cnt_r, cnt_n;
    logic [lg_els_lp-1:0]               base_r, base_n;
    logic [block_size_in_words_p-1:0]   mask_r, mask_n;

    logic [data_width_p-1:0]            mem_r [els_p];
    logic                               mem_we;
    logic [lg_els_lp-1:0]               mem_addr;

    logic                               pkt_write_not_read;
    logic [block_size_in_words_p-1:0]   pkt_mask;
    logic [addr_width_p-1:0]            pkt_addr;
    logic [addr_width_p-1:0]            pkt_word_addr;
    logic [lg_els_lp-1:0]               pkt_base;
    logic                               last_beat;

    assign {pkt_write_not_read, pkt_mask, pkt_addr} = dma_pkt_i;

    // Word address truncated mod els_p; high bits alias by design.
    assign pkt_word_addr = pkt_addr >> byte_offset_lp;
    assign pkt_base      = pkt_word_addr[lg_els_lp-1:0] & ~block_mask_lp;

    logic unused_addr_bits;
    assign unused_addr_bits = ^pkt_word_addr;

    assign last_beat = (cnt_r == last_cnt_lp);
    assign mem_addr  = base_r + lg_els_lp'(cnt_r);

    always_comb begin
        state_n         = state_r;
        cnt_n           = cnt_r;
        base_n          = base_r;
        mask_n          = mask_r;
        dma_pkt_yumi_o  = 1'b0;
        dma_data_v_o    = 1'b0;
        dma_data_yumi_o = 1'b0;
        mem_we          = 1'b0;

        case (state_r)
            IDLE: begin
                dma_pkt_yumi_o = dma_pkt_v_i;
                if (dma_pkt_v_i) begin
                    mask_n  = pkt_mask;
                    base_n  = pkt_base;
                    cnt_n   = '0;
                    state_n = pkt_write_not_read ? WRITE : READ;
                end
            end

            READ: begin
                dma_data_v_o = 1'b1;
                if (dma_data_ready_i) begin
                    cnt_n = cnt_r + 1'b1;
                    if (last_beat) begin
                        cnt_n   = '0;
                        state_n = IDLE;
                    end
                end
            end

            WRITE: begin
                dma_data_yumi_o = dma_data_v_i;
                if (dma_data_v_i) begin
                    // Masked-off words are still consumed, just not stored.
                    mem_we = mask_r[cnt_r];
                    cnt_n  = cnt_r + 1'b1;
                    if (last_beat) begin
                        cnt_n   = '0;
                        state_n = IDLE;
                    end
                end
            end

            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
            cnt_r   <= '0;
        end else begin
            state_r <= state_n;
            cnt_r   <= cnt_n;
        end
    end

    always_ff @(posedge clk) begin
        base_r <= base_n;
        mask_r <= mask_n;
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_r[mem_addr] <= dma_data_i;
        end
    end

    assign dma_data_o = mem_r[mem_addr];
    assign busy_o     = (state_r != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_bsg_cache_dma_mem_responder.sv
//------------------------------------------------------------------------------
// Module  : tb_bsg_cache_dma_mem_responder
// Brief   : Scoreboard bench for bsg_cache_dma_mem_responder.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_bsg_cache_dma_mem_responder;

    localparam int AW  = 30;
    localparam int DW  = 32;
    localparam int B   = 8;
    localparam int ELS = 1024;
    localparam int PW  = 1 + B + AW;

    logic          clk = 1'b0;
    logic          reset;
    logic [PW-1:0] dma_pkt_i;
    logic          dma_pkt_v_i;
    logic          dma_pkt_yumi_o;
    logic [DW-1:0] dma_data_o;
    logic          dma_data_v_o;
    logic          dma_data_ready_i;
    logic [DW-1:0] dma_data_i;
    logic          dma_data_v_i;
    logic          dma_data_yumi_o;
    logic          busy_o;

    bsg_cache_dma_mem_responder #(
        .addr_width_p         (AW),
        .data_width_p         (DW),
        .block_size_in_words_p(B),
        .els_p                (ELS)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .dma_pkt_i       (dma_pkt_i),
        .dma_pkt_v_i     (dma_pkt_v_i),
        .dma_pkt_yumi_o  (dma_pkt_yumi_o),
        .dma_data_o      (dma_data_o),
        .dma_data_v_o    (dma_data_v_o),
        .dma_data_ready_i(dma_data_ready_i),
        .dma_data_i      (dma_data_i),
        .dma_data_v_i    (dma_data_v_i),
        .dma_data_yumi_o (dma_data_yumi_o),
        .busy_o          (busy_o)
    );

    always #5 clk = ~clk;

    int            checks = 0;
    int            errors = 0;
    logic [DW-1:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Monitor: pops one expected word per accepted fill beat, checks hold under stall.
    logic [DW-1:0] mon_prev;
    logic          mon_have_prev = 1'b0;
    logic [DW-1:0] mon_exp;

    always @(negedge clk) begin
        if (!reset && dma_data_v_o) begin
            if (dma_data_ready_i) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", 64'd1, 64'd0);
                end else begin
                    mon_exp = exp_q.pop_front();
                    check("read_data", 64'(dma_data_o), 64'(mon_exp));
                end
                mon_have_prev = 1'b0;
            end else begin
                if (mon_have_prev) check("stall_hold", 64'(dma_data_o), 64'(mon_prev));
                mon_prev      = dma_data_o;
                mon_have_prev = 1'b1;
            end
        end else begin
            mon_have_prev = 1'b0;
        end
    end

    function automatic logic [B*DW-1:0] seq(input logic [DW-1:0] start);
        logic [B*DW-1:0] r;
        for (int i = 0; i < B; i++) r[i*DW +: DW] = start + DW'(i);
        return r;
    endfunction

    task automatic send_pkt(input logic wnr, input logic [B-1:0] m, input logic [AW-1:0] a);
        int n;
        n = 0;
        @(posedge clk); #1;
        dma_pkt_i   = {wnr, m, a};
        dma_pkt_v_i = 1'b1;
        forever begin
            @(negedge clk);
            if (dma_pkt_yumi_o) break;
            n++;
            if (n > 50) begin
                check("pkt_timeout", 64'd0, 64'd1);
                break;
            end
        end
        @(posedge clk); #1;
        dma_pkt_v_i = 1'b0;
    endtask

    task automatic write_block(input logic [B*DW-1:0] d, input bit rnd);
        int beat;
        int cyc;
        beat = 0;
        cyc  = 0;
        while (beat < B) begin
            dma_data_v_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            dma_data_i   = d[beat*DW +: DW];
            @(negedge clk);
            check("evict_yumi", 64'(dma_data_yumi_o), 64'(dma_data_v_i));
            if (dma_data_yumi_o) beat++;
            cyc++;
            if (cyc > 200) begin
                check("write_timeout", 64'd0, 64'd1);
                break;
            end
            @(posedge clk); #1;
        end
        dma_data_v_i = 1'b0;
        @(negedge clk);
        check("write_idle", 64'(busy_o), 64'd0);
    endtask

    task automatic read_block(input logic [B*DW-1:0] d, input int nbeats, input bit rnd,
                              output int cycles);
        int beat;
        for (int i = 0; i < nbeats; i++) exp_q.push_back(d[i*DW +: DW]);
        beat   = 0;
        cycles = 0;
        while (beat < nbeats) begin
            dma_data_ready_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            check("read_busy", 64'(busy_o), 64'd1);
            if (dma_data_v_o && dma_data_ready_i) beat++;
            cycles++;
            if (cycles > 200) begin
                check("read_timeout", 64'd0, 64'd1);
                break;
            end
            @(posedge clk); #1;
        end
        dma_data_ready_i = 1'b0;
    endtask

    logic [B*DW-1:0] exp_blk;
    int              cyc;
    int              beats;

    initial begin
        reset            = 1'b1;
        dma_pkt_i        = '0;
        dma_pkt_v_i      = 1'b0;
        dma_data_ready_i = 1'b0;
        dma_data_i       = '0;
        dma_data_v_i     = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        @(negedge clk);
        check("reset_busy",      64'(busy_o),          64'd0);
        check("reset_data_v",    64'(dma_data_v_o),    64'd0);
        check("reset_data_yumi", 64'(dma_data_yumi_o), 64'd0);
        check("reset_pkt_yumi",  64'(dma_pkt_yumi_o),  64'd0);

        // Full write then read, ready held high: 8 beats, 8 busy cycles.
        send_pkt(1'b1, 8'hFF, 30'h100);
        write_block(seq(32'hA0), 1'b0);
        send_pkt(1'b0, 8'hFF, 30'h100);
        read_block(seq(32'hA0), B, 1'b0, cyc);
        check("read_cycles", 64'(cyc), 64'd8);
        @(negedge clk);
        check("read_idle_busy", 64'(busy_o),       64'd0);
        check("read_idle_v",    64'(dma_data_v_o), 64'd0);

        // Masked write over a prefilled block.
        send_pkt(1'b1, 8'hFF, 30'h200);
        write_block({B{32'h11}}, 1'b0);
        send_pkt(1'b1, 8'h0F, 30'h200);
        write_block(seq(32'hB0), 1'b0);
        exp_blk = {32'h11, 32'h11, 32'h11, 32'h11, 32'hB3, 32'hB2, 32'hB1, 32'hB0};
        send_pkt(1'b0, 8'hFF, 30'h200);
        read_block(exp_blk, B, 1'b0, cyc);

        // Mid-block address aligns to 0x100; +4096 bytes aliases to it.
        send_pkt(1'b1, 8'hFF, 30'h11C);
        write_block(seq(32'hC0), 1'b0);
        send_pkt(1'b0, 8'hFF, 30'h100);
        read_block(seq(32'hC0), B, 1'b0, cyc);
        send_pkt(1'b0, 8'hFF, 30'h1100);
        read_block(seq(32'hC0), B, 1'b0, cyc);

        // Backpressure on both channels.
        send_pkt(1'b0, 8'hFF, 30'h100);
        read_block(seq(32'hC0), B, 1'b1, cyc);
        send_pkt(1'b1, 8'hFF, 30'h300);
        write_block(seq(32'hD0), 1'b1);
        send_pkt(1'b0, 8'hFF, 30'h300);
        read_block(seq(32'hD0), B, 1'b1, cyc);

        // Packet held valid through a read: next yumi only after the last beat.
        @(posedge clk); #1;
        dma_pkt_i   = {1'b0, 8'hFF, 30'h100};
        dma_pkt_v_i = 1'b1;
        @(negedge clk);
        check("busy_first_yumi", 64'(dma_pkt_yumi_o), 64'd1);
        @(posedge clk); #1;
        for (int i = 0; i < B; i++) exp_q.push_back(32'hC0 + DW'(i));
        beats = 0;
        cyc   = 0;
        while (beats < B) begin
            dma_data_ready_i = 1'b1;
            @(negedge clk);
            check("no_early_yumi", 64'(dma_pkt_yumi_o), 64'd0);
            if (dma_data_v_o) beats++;
            cyc++;
            if (cyc > 50) begin
                check("busy_read_timeout", 64'd0, 64'd1);
                break;
            end
            @(posedge clk); #1;
        end
        @(negedge clk);
        check("second_yumi", 64'(dma_pkt_yumi_o), 64'd1);
        @(posedge clk); #1;
        dma_pkt_v_i = 1'b0;
        read_block(seq(32'hC0), B, 1'b0, cyc);
        @(negedge clk);
        check("second_read_idle", 64'(busy_o), 64'd0);

        // Reset after four beats of a read, then a clean read.
        send_pkt(1'b0, 8'hFF, 30'h300);
        read_block(seq(32'hD0), 4, 1'b0, cyc);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("abort_busy",   64'(busy_o),       64'd0);
        check("abort_data_v", 64'(dma_data_v_o), 64'd0);
        send_pkt(1'b0, 8'hFF, 30'h300);
        read_block(seq(32'hD0), B, 1'b0, cyc);
        @(negedge clk);
        check("final_idle",     64'(busy_o),        64'd0);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
